// File: rtl/ham_secded_decoder_if.sv
// Handshake bundle for the SECDED decoder: code-word input side and decoded-result output side.
interface ham_secded_decoder_if #(
    parameter int unsigned R = 3
);
    localparam int unsigned N = (1 << R) - 1;
    localparam int unsigned K = N - R;

    logic             in_valid;
    logic             in_ready;
    logic [N:0]       in_code;
    logic             in_corr_en;

    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_data;
    logic             out_sec;
    logic             out_ded;
    logic [R-1:0]     out_syndrome;

    modport master (
        output in_valid, in_code, in_corr_en, out_ready,
        input  in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
    );

    modport slave (
        input  in_valid, in_code, in_corr_en, out_ready,
        output in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
    );
endinterface

// File: rtl/ham_secded_decoder.sv
// Two-stage Hamming SECDED decoder with valid/ready on both sides and
// saturating SEC/DED event counters for link-health monitoring.
module ham_secded_decoder #(
    parameter int unsigned R     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ham_secded_decoder_if.slave      bus,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         sec_count,
    output logic [CNT_W-1:0]         ded_count
);
    localparam int unsigned N = (1 << R) - 1;
    localparam int unsigned K = N - R;
    localparam int unsigned W = N + 1;

    // XOR of the 1-based positions of every set bit among positions 1..N.
    function automatic logic [R-1:0] calc_syndrome(input logic [W-1:0] code);
        logic [R-1:0] s;
        logic [W-1:0] sh;
        s = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sh = code >> i;
            if (sh[0]) s = s ^ R'(i + 1);
        end
        return s;
    endfunction

    // Gather non-power-of-two positions in ascending order into the data word.
    function automatic logic [K-1:0] extract_data(input logic [W-1:0] code);
        logic [K-1:0] d;
        logic [W-1:0] sh;
        int unsigned  k;
        d = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                sh = code >> (pos - 1);
                d  = d | (K'(sh[0]) << k);
                k  = k + 1;
            end
        end
        return d;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_code_q,  s1_code_d;
    logic             s1_corr_q,  s1_corr_d;
    logic [R-1:0]     s1_syn_q,   s1_syn_d;
    logic             s1_par_q,   s1_par_d;

    logic             s2_valid_q, s2_valid_d;
    logic [K-1:0]     s2_data_q,  s2_data_d;
    logic             s2_sec_q,   s2_sec_d;
    logic             s2_ded_q,   s2_ded_d;
    logic [R-1:0]     s2_syn_q,   s2_syn_d;

    logic [CNT_W-1:0] sec_cnt_q,  sec_cnt_d;
    logic [CNT_W-1:0] ded_cnt_q,  ded_cnt_d;

    logic             adv1_c;
    logic             adv2_c;
    logic             sec_c;
    logic             ded_c;
    logic [W-1:0]     fixed_code_c;

    // Ready chain: a stage may load when it is empty or its successor drains it.
    always_comb begin
        adv2_c = !s2_valid_q || bus.out_ready;
        adv1_c = !s1_valid_q || adv2_c;
    end

    // Classify the stage-1 word and apply single-bit correction when enabled.
    always_comb begin
        sec_c        = s1_par_q;
        ded_c        = !s1_par_q && (s1_syn_q != '0);
        fixed_code_c = s1_code_q;
        if (sec_c && (s1_syn_q != '0) && s1_corr_q) begin
            fixed_code_c = s1_code_q ^ (W'(1) << (s1_syn_q - R'(1)));
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_corr_d  = s1_corr_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sec_d   = s2_sec_q;
        s2_ded_d   = s2_ded_q;
        s2_syn_d   = s2_syn_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;

        if (adv1_c) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_code_d = bus.in_code;
                s1_corr_d = bus.in_corr_en;
                s1_syn_d  = calc_syndrome(bus.in_code);
                s1_par_d  = ^bus.in_code;
            end
        end

        // Output registers only move on a transfer, so a stalled result stays put.
        if (adv2_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = extract_data(fixed_code_c);
                s2_sec_d  = sec_c;
                s2_ded_d  = ded_c;
                s2_syn_d  = s1_syn_q;
            end
        end

        // Clear beats a same-cycle increment; increments stop at all-ones.
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (adv2_c && s1_valid_q) begin
            if (sec_c && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
            if (ded_c && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_corr_q  <= 1'b0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sec_q   <= 1'b0;
            s2_ded_q   <= 1'b0;
            s2_syn_q   <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_corr_q  <= s1_corr_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sec_q   <= s2_sec_d;
            s2_ded_q   <= s2_ded_d;
            s2_syn_q   <= s2_syn_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign bus.in_ready     = adv1_c;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_data     = s2_data_q;
    assign bus.out_sec      = s2_sec_q;
    assign bus.out_ded      = s2_ded_q;
    assign bus.out_syndrome = s2_syn_q;
    assign sec_count        = sec_cnt_q;
    assign ded_count        = ded_cnt_q;
endmodule

// File: tb/tb_ham_secded_decoder.sv
// Scoreboard bench for ham_secded_decoder (R=3, CNT_W=2); the reference decodes by nearest-codeword search.
module tb_ham_secded_decoder;
    localparam int unsigned R     = 3;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [3:0] data;
        logic       sec;
        logic       ded;
        logic [2:0] syn;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cnt_clr;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;

    ham_secded_decoder_if #(.R(R)) bus ();

    ham_secded_decoder #(.R(R), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .sec_count (sec_count),
        .ded_count (ded_count)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_sec = '0;
    logic [CNT_W-1:0] exp_ded = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Classic (7,4) Hamming plus overall parity in bit 7.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] cw;
        cw[2] = d[0];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    function automatic logic [3:0] raw_data(input logic [7:0] c);
        return {c[6], c[5], c[4], c[2]};
    endfunction

    function automatic exp_t model(input logic [7:0] c, input logic corr);
        exp_t       e;
        int         best;
        int         n;
        logic [3:0] bd;
        logic [7:0] bdiff;
        logic [7:0] cw;
        logic [2:0] syn;
        best  = 99;
        bd    = '0;
        bdiff = '0;
        for (int d = 0; d < 16; d++) begin
            cw = encode(4'(d));
            n  = $countones(cw ^ c);
            if (n < best) begin
                best  = n;
                bd    = 4'(d);
                bdiff = cw ^ c;
            end
        end
        syn = '0;
        for (int i = 0; i < 7; i++) if (bdiff[i]) syn = syn ^ 3'(i + 1);
        e.syn  = syn;
        e.sec  = (best == 1);
        e.ded  = (best == 2);
        e.data = (best == 0 || (best == 1 && corr)) ? bd : raw_data(c);
        return e;
    endfunction

    // One cycle: drive at negedge, settle, account for transfers that the next posedge performs.
    task automatic step(input logic v, input logic [7:0] code, input logic corr,
                        input logic ordy, input logic clr, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_code    = code;
        bus.in_corr_en = corr;
        bus.out_ready  = ordy;
        cnt_clr        = clr;
        #1;
        acc = v && bus.in_ready;
        if (acc) begin
            e = model(code, corr);
            sb.push_back(e);
            if (e.sec && exp_sec != CNT_MAX) exp_sec = exp_sec + 1'b1;
            if (e.ded && exp_ded != CNT_MAX) exp_ded = exp_ded + 1'b1;
        end
        if (bus.out_valid && ordy) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out_valid", 32'(bus.out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check_eq("out_data", 32'(bus.out_data), 32'(e.data));
                check_eq("out_sec", 32'(bus.out_sec), 32'(e.sec));
                check_eq("out_ded", 32'(bus.out_ded), 32'(e.ded));
                check_eq("out_syndrome", 32'(bus.out_syndrome), 32'(e.syn));
            end
        end
    endtask

    task automatic idle(input logic clr);
        logic a;
        step(1'b0, 8'h00, 1'b1, 1'b1, clr, a);
    endtask

    task automatic send(input logic [7:0] code, input logic corr);
        logic a;
        int   tries;
        a     = 1'b0;
        tries = 0;
        while (!a && tries < 20) begin
            step(1'b1, code, corr, 1'b1, 1'b0, a);
            tries++;
        end
        if (!a) check_eq("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            idle(1'b0);
        end
        check_eq("drain_left", 32'(sb.size()), 32'(0));
    endtask

    task automatic clear_counts();
        idle(1'b1);
        exp_sec = '0;
        exp_ded = '0;
        idle(1'b0);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_sec_count"}, 32'(sec_count), 32'(exp_sec));
        check_eq({tag, "_ded_count"}, 32'(ded_count), 32'(exp_ded));
    endtask

    logic [7:0] words[3];
    logic [8:0] snap;
    logic       acc;
    int         idx;
    logic [7:0] code;

    initial begin
        rst            = 1'b1;
        cnt_clr        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_code    = '0;
        bus.in_corr_en = 1'b1;
        bus.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check_eq("rst_out_data", 32'(bus.out_data), 32'(0));
        check_eq("rst_flags", 32'({bus.out_sec, bus.out_ded}), 32'(0));
        check_eq("rst_syndrome", 32'(bus.out_syndrome), 32'(0));
        check_counts("rst");

        // Two-cycle latency from acceptance to out_valid.
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, acc);
        check_eq("lat_accept", 32'(acc), 32'(1));
        idle(1'b0);
        check_eq("lat_valid_cycle1", 32'(bus.out_valid), 32'(0));
        idle(1'b0);
        check_eq("lat_valid_cycle2", 32'(bus.out_valid), 32'(1));
        drain();

        // Directed decode cases, back to back.
        clear_counts();
        send(8'hFF, 1'b1);
        send(8'h10, 1'b1);
        send(8'hBF, 1'b1);
        send(8'h80, 1'b1);
        send(8'h03, 1'b1);
        drain();
        check_counts("directed");

        // Detect-only: raw data, event still counted.
        clear_counts();
        send(8'hBF, 1'b0);
        drain();
        check_counts("detect_only");

        // Saturation: five SEC words into a 2-bit counter.
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            code = encode(4'($urandom_range(0, 15))) ^ (8'h01 << $urandom_range(0, 7));
            send(code, 1'b1);
        end
        drain();
        check_counts("saturate");

        // Clear in the same cycle the SEC word enters stage 2.
        clear_counts();
        step(1'b1, 8'h10, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
        exp_sec = '0;
        exp_ded = '0;
        drain();
        check_counts("clear_wins");
        send(8'h10, 1'b1);
        drain();
        check_counts("after_clear");

        // Back-pressure: five stalled cycles with three words offered.
        words[0] = 8'h10;
        words[1] = 8'h03;
        words[2] = 8'hBF;
        idx = 0;
        snap = '0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, words[idx], 1'b1, 1'b0, 1'b0, acc);
            if (c >= 2) begin
                check_eq("stall_in_ready", 32'(bus.in_ready), 32'(0));
                check_eq("stall_out_valid", 32'(bus.out_valid), 32'(1));
                if (c == 2) snap = {bus.out_data, bus.out_sec, bus.out_ded, bus.out_syndrome};
                else check_eq("stall_stable", 32'({bus.out_data, bus.out_sec, bus.out_ded, bus.out_syndrome}), 32'(snap));
            end
            if (acc) idx++;
        end
        check_eq("stall_accepted", 32'(idx), 32'(2));
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step(1'b1, words[idx], 1'b1, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        check_eq("stall_release_all", 32'(idx), 32'(3));
        drain();

        // Random traffic with random back-pressure and correction mode.
        clear_counts();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0:       code = encode(4'($urandom_range(0, 15)));
                1:       code = encode(4'($urandom_range(0, 15))) ^ (8'h01 << $urandom_range(0, 7));
                default: code = 8'($urandom_range(0, 255));
            endcase
            step(1'($urandom_range(0, 3) != 0), code, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 7), 1'b0, acc);
        end
        drain();
        check_counts("random");

        // Reset mid-stream discards in-flight words.
        send(8'h10, 1'b1);
        send(8'h03, 1'b1);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'(1));
        sb.delete();
        exp_sec = '0;
        exp_ded = '0;
        check_counts("midrst");
        @(negedge clk);
        rst = 1'b0;
        send(8'hFF, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
